// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the multi-channel PWM fader: default sizes,
// per-channel fade state encoding and prescaler sizing helper.
package pwm_fader_pkg;

   localparam int DEF_WIDTH        = 10;
   localparam int DEF_CHANNELS     = 4;
   localparam int DEF_FADE_PERIODS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } ch_state_t;

   // Prescaler must hold 0..periods-1; a single period still needs one bit.
   function automatic int presc_width(input int periods);
      return (periods > 1) ? $clog2(periods) : 1;
   endfunction

endpackage

// File: rtl/pwm_fader_ch.sv
// One PWM channel: target/current/shadow levels, fade FSM, duty comparator
// and registered output with selectable polarity.
module pwm_fader_ch
   import pwm_fader_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] cnt,
   input  logic             wrap,
   input  logic             step,
   input  logic             wr_hit,
   input  logic [WIDTH-1:0] wr_level,
   input  logic             wr_fade,
   output logic             pwm_out,
   output logic             busy
);

   ch_state_t        state, state_next;
   logic [WIDTH-1:0] current, current_next;
   logic [WIDTH-1:0] target, target_next;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] current_up;
   logic [WIDTH-1:0] current_dn;

   assign current_up = current + 1'b1;
   assign current_dn = current - 1'b1;

   // A write always takes priority, so a step landing on the same edge is dropped.
   always_comb begin
      state_next   = state;
      current_next = current;
      target_next  = target;
      if (wr_hit) begin
         target_next = wr_level;
         if (!wr_fade) begin
            current_next = wr_level;
            state_next   = ST_IDLE;
         end else if (wr_level > current) begin
            state_next = ST_UP;
         end else if (wr_level < current) begin
            state_next = ST_DOWN;
         end else begin
            state_next = ST_IDLE;
         end
      end else if (step) begin
         case (state)
            ST_UP: begin
               current_next = current_up;
               if (current_up == target) state_next = ST_IDLE;
            end
            ST_DOWN: begin
               current_next = current_dn;
               if (current_dn == target) state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Shadow only follows current at the period wrap, keeping every pulse whole.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         current <= '0;
         target  <= '0;
         shadow  <= '0;
         pwm_out <= ACTIVE_LOW;
      end else begin
         state   <= state_next;
         current <= current_next;
         target  <= target_next;
         if (wrap) shadow <= current;
         pwm_out <= (cnt < shadow) ^ ACTIVE_LOW;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel phase-aligned PWM generator: shared period counter, fade
// prescaler and write decode feeding one pwm_fader_ch per output.
module pwm_fader
   import pwm_fader_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int CH_W         = 2,
   parameter int FADE_PERIODS = DEF_FADE_PERIODS,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_level,
   input  logic                wr_fade,
   output logic [CHANNELS-1:0] pwm_out,
   output logic [CHANNELS-1:0] busy,
   output logic                period_tick
);

   localparam int PW = presc_width(FADE_PERIODS);
   localparam logic [WIDTH-1:0] LAST_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

   logic [WIDTH-1:0] cnt;
   logic [PW-1:0]    presc;
   logic             wrap;
   logic             step;

   assign wrap = (cnt == '1);
   assign step = wrap && (presc == PW'(FADE_PERIODS - 1));

   // period_tick is decoded one cycle early so the registered pulse lines up with cnt at max.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         presc       <= '0;
         period_tick <= 1'b0;
      end else begin
         cnt         <= cnt + 1'b1;
         period_tick <= (cnt == LAST_M1);
         if (wrap) presc <= step ? '0 : presc + 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic wr_hit;
      assign wr_hit = wr_en && (wr_ch == CH_W'(i));

      pwm_fader_ch #(
         .WIDTH      (WIDTH),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .cnt      (cnt),
         .wrap     (wrap),
         .step     (step),
         .wr_hit   (wr_hit),
         .wr_level (wr_level),
         .wr_fade  (wr_fade),
         .pwm_out  (pwm_out[i]),
         .busy     (busy[i])
      );
   end

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader (WIDTH=4, CHANNELS=2, FADE_PERIODS=2, active-high):
// directed scenarios plus random writes against a behavioural level model.
module tb_pwm_fader;

   localparam int WIDTH = 4;
   localparam int NCH   = 2;
   localparam int FP    = 2;
   localparam int MAXC  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             wr_en;
   logic [1:0]       wr_ch;
   logic [WIDTH-1:0] wr_level;
   logic             wr_fade;
   logic [NCH-1:0]   pwm_out;
   logic [NCH-1:0]   busy;
   logic             period_tick;

   int n_checks = 0;
   int n_pass   = 0;

   int   m_cnt, m_presc;
   int   m_cur[NCH];
   int   m_tgt[NCH];
   int   m_shadow[NCH];
   logic [NCH-1:0] m_pwm;
   logic m_tick;

   always #5 clk = ~clk;

   pwm_fader #(
      .WIDTH        (WIDTH),
      .CHANNELS     (NCH),
      .CH_W         (2),
      .FADE_PERIODS (FP),
      .ACTIVE_LOW   (1'b0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_level    (wr_level),
      .wr_fade     (wr_fade),
      .pwm_out     (pwm_out),
      .busy        (busy),
      .period_tick (period_tick)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
   endtask

   // Level model: a channel is fading whenever current differs from target;
   // each step edge moves current one LSB toward target.
   task automatic modelEdge();
      bit wrap, step;
      if (reset) begin
         m_cnt = 0; m_presc = 0; m_tick = 1'b0; m_pwm = '0;
         for (int c = 0; c < NCH; c++) begin
            m_cur[c] = 0; m_tgt[c] = 0; m_shadow[c] = 0;
         end
         return;
      end
      wrap   = (m_cnt == MAXC);
      step   = wrap && (m_presc == FP - 1);
      m_tick = (m_cnt == MAXC - 1);
      for (int c = 0; c < NCH; c++) begin
         m_pwm[c] = (m_cnt < m_shadow[c]);
         if (wrap) m_shadow[c] = m_cur[c];
         if (wr_en && int'(wr_ch) == c) begin
            m_tgt[c] = int'(wr_level);
            if (!wr_fade) m_cur[c] = int'(wr_level);
         end else if (step) begin
            if (m_cur[c] < m_tgt[c]) m_cur[c]++;
            else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
         end
      end
      if (wrap) m_presc = step ? 0 : m_presc + 1;
      m_cnt = (m_cnt + 1) % (MAXC + 1);
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input int ch,
                                input int lvl, input logic fd);
      logic [NCH-1:0] exp_busy;
      reset    = rst;
      wr_en    = en;
      wr_ch    = 2'(ch);
      wr_level = WIDTH'(lvl);
      wr_fade  = fd;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      for (int c = 0; c < NCH; c++) exp_busy[c] = (m_cur[c] != m_tgt[c]);
      checkOutput("pwm_out", 32'(pwm_out), 32'(m_pwm));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("period_tick", 32'(period_tick), 32'(m_tick));
      wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic waitCnt(input int c);
      for (int k = 0; k < 16 && m_cnt != c; k++) idle(1);
   endtask

   // Counts active cycles over one full period directly from the output pin.
   task automatic checkDuty(input string tag, input int ch, input int exp);
      int hi = 0;
      for (int k = 0; k < MAXC + 1; k++) begin
         idle(1);
         hi += int'(pwm_out[ch]);
      end
      checkOutput(tag, 32'(hi), 32'(exp));
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_level = '0; wr_fade = 1'b0;
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
      idle(64);

      // Immediate write mid-period, then steady duty of 5.
      waitCnt(7);
      applyStimulus(1'b0, 1'b1, 0, 5, 1'b0);
      idle(24);
      checkDuty("duty_ch0_5", 0, 5);
      checkDuty("duty_ch1_0", 1, 0);

      // Fade ch1 up to 3.
      applyStimulus(1'b0, 1'b1, 1, 3, 1'b1);
      idle(160);
      checkDuty("duty_ch1_3", 1, 3);

      // Fade toward 15, reverse to 2 once current reaches 4.
      applyStimulus(1'b0, 1'b1, 1, 15, 1'b1);
      for (int k = 0; k < 200 && m_cur[1] != 4; k++) idle(1);
      applyStimulus(1'b0, 1'b1, 1, 2, 1'b1);
      idle(120);
      checkDuty("duty_ch1_2", 1, 2);

      // Fade write landing exactly on a step edge.
      applyStimulus(1'b0, 1'b1, 0, 10, 1'b1);
      idle(40);
      for (int k = 0; k < 64 && !(m_cnt == MAXC && m_presc == FP - 1); k++) idle(1);
      applyStimulus(1'b0, 1'b1, 0, 12, 1'b1);
      idle(300);

      // Extreme levels and an out-of-range channel write.
      applyStimulus(1'b0, 1'b1, 0, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1, 15, 1'b0);
      idle(40);
      checkDuty("duty_ch0_0", 0, 0);
      checkDuty("duty_ch1_15", 1, 15);
      applyStimulus(1'b0, 1'b1, 3, 9, 1'b0);
      applyStimulus(1'b0, 1'b1, 2, 9, 1'b1);
      idle(40);
      checkDuty("duty_ch1_15_kept", 1, 15);

      // Reset in the middle of a fade with outputs active.
      applyStimulus(1'b0, 1'b1, 1, 0, 1'b1);
      idle(37);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
      idle(48);
      checkDuty("duty_after_reset", 1, 0);

      // Random writes, with occasional resets.
      for (int k = 0; k < 2500; k++) begin
         applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, MAXC)),
                       1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
